// File: rtl/gf_sched_pkg.sv
// Shared types and constants for the GF datapath scheduler.
package gf_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_WIDTH   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Bit positions inside a requester's 4-bit op field {sum,exp,red,carry_option}
    localparam int OP_CARRY = 0;
    localparam int OP_RED   = 1;
    localparam int OP_EXP   = 2;
    localparam int OP_SUM   = 3;

    localparam int CNT_W = 8;

endpackage

// File: rtl/gf_op_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_vld
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            idx = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : sum[ID_W-1:0];
            if (!gnt_vld && req[idx]) begin
                gnt_vld      = 1'b1;
                gnt_idx      = idx;
                gnt[idx]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gf_op_scheduler.sv
// Shares one carry-less/GF datapath among NUM_REQ requesters, one operation in flight,
// with round-robin arbitration, a run timeout and a tagged valid/ready response.
module gf_op_scheduler
    import gf_sched_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REQ    = 4,
    parameter  int TIMEOUT    = 255,
    localparam int DW         = DATA_WIDTH,
    localparam int ID_W       = $clog2(NUM_REQ),
    localparam int WW         = $clog2(DATA_WIDTH) + 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0][3:0]          req_op,
    input  logic [NUM_REQ-1:0][WW-1:0]       req_width,
    input  logic [NUM_REQ-1:0][DW-1:0]       req_a,
    input  logic [NUM_REQ-1:0][DW-1:0]       req_b,
    input  logic [NUM_REQ-1:0][DW:0]         req_poly,
    input  logic [NUM_REQ-1:0][2*DW-1:0]     req_reduc,
    output logic                             dp_op_enable,
    input  logic                             dp_op_finish,
    output logic                             dp_sum_funct,
    output logic                             dp_exp_funct,
    output logic                             dp_red_funct,
    output logic                             dp_carry_option,
    output logic [WW-1:0]                    dp_in_width,
    output logic [DW-1:0]                    dp_in_a,
    output logic [DW-1:0]                    dp_in_b,
    output logic [DW:0]                      dp_polyn,
    output logic [2*DW-1:0]                  dp_reduc,
    input  logic [DW-1:0]                    dp_out,
    input  logic [DW-1:0]                    dp_out_poly,
    input  logic [2*DW-1:0]                  dp_out_mult,
    input  logic                             dp_out_carry,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [ID_W-1:0]                  resp_id,
    output logic [DW-1:0]                    resp_out,
    output logic [DW-1:0]                    resp_poly,
    output logic [2*DW-1:0]                  resp_mult,
    output logic                             resp_carry,
    output logic [1:0]                       resp_err
);

    typedef struct packed {
        logic [DW-1:0]   out;
        logic [DW-1:0]   poly;
        logic [2*DW-1:0] mult;
        logic            carry;
    } res_t;

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               en_q, en_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WW-1:0]      width_q, width_d;
    logic [DW-1:0]      a_q, a_d, b_q, b_d;
    logic [DW:0]        poly_q, poly_d;
    logic [2*DW-1:0]    reduc_q, reduc_d;
    logic [ID_W-1:0]    id_q, id_d;
    res_t               res_q, res_d;
    logic [1:0]         err_q, err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_vld;
    logic               width_bad;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign width_bad = (req_width[gnt_idx] == '0) || (req_width[gnt_idx] > WW'(DW));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        en_d      = en_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        width_d   = width_q;
        a_d       = a_q;
        b_d       = b_q;
        poly_d    = poly_q;
        reduc_d   = reduc_q;
        id_d      = id_q;
        res_d     = res_q;
        err_d     = err_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    req_ready = gnt & {NUM_REQ{~reset}};
                    op_d      = req_op[gnt_idx];
                    width_d   = req_width[gnt_idx];
                    a_d       = req_a[gnt_idx];
                    b_d       = req_b[gnt_idx];
                    poly_d    = req_poly[gnt_idx];
                    reduc_d   = req_reduc[gnt_idx];
                    id_d      = gnt_idx;
                    if (width_bad) begin
                        err_d   = ERR_WIDTH;
                        res_d   = '0;
                        state_d = RESP;
                    end else begin
                        en_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // A finish seen in the first RUN cycle belongs to the previous op.
                if (cnt_q != '0 && dp_op_finish) begin
                    res_d.out   = dp_out;
                    res_d.poly  = dp_out_poly;
                    res_d.mult  = dp_out_mult;
                    res_d.carry = dp_out_carry;
                    err_d       = ERR_OK;
                    en_d        = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == TO_CNT) begin
                    res_d   = '0;
                    err_d   = ERR_TIMEOUT;
                    en_d    = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    ptr_d   = (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
            width_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            poly_q  <= '0;
            reduc_q <= '0;
            id_q    <= '0;
            res_q   <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            width_q <= width_d;
            a_q     <= a_d;
            b_q     <= b_d;
            poly_q  <= poly_d;
            reduc_q <= reduc_d;
            id_q    <= id_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign dp_op_enable    = en_q;
    assign dp_sum_funct    = op_q[OP_SUM];
    assign dp_exp_funct    = op_q[OP_EXP];
    assign dp_red_funct    = op_q[OP_RED];
    assign dp_carry_option = op_q[OP_CARRY];
    assign dp_in_width     = width_q;
    assign dp_in_a         = a_q;
    assign dp_in_b         = b_q;
    assign dp_polyn        = poly_q;
    assign dp_reduc        = reduc_q;

    assign resp_valid = (state_q == RESP);
    assign resp_id    = id_q;
    assign resp_out   = res_q.out;
    assign resp_poly  = res_q.poly;
    assign resp_mult  = res_q.mult;
    assign resp_carry = res_q.carry;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_gf_op_scheduler.sv
// Bench for gf_op_scheduler: behavioural datapath, response scoreboard, vector table and corner sequences.
module tb_gf_op_scheduler;

    localparam int DW = 32, NR = 4, IDW = 2, WW = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NR-1:0]            req_valid, req_ready;
    logic [NR-1:0][3:0]       req_op;
    logic [NR-1:0][WW-1:0]    req_width;
    logic [NR-1:0][DW-1:0]    req_a, req_b;
    logic [NR-1:0][DW:0]      req_poly;
    logic [NR-1:0][2*DW-1:0]  req_reduc;
    logic                     dp_op_enable, dp_op_finish;
    logic                     dp_sum_funct, dp_exp_funct, dp_red_funct, dp_carry_option;
    logic [WW-1:0]            dp_in_width;
    logic [DW-1:0]            dp_in_a, dp_in_b, dp_out, dp_out_poly;
    logic [DW:0]              dp_polyn;
    logic [2*DW-1:0]          dp_reduc, dp_out_mult;
    logic                     dp_out_carry;
    logic                     resp_valid, resp_ready, resp_carry;
    logic [IDW-1:0]           resp_id;
    logic [DW-1:0]            resp_out, resp_poly;
    logic [2*DW-1:0]          resp_mult;
    logic [1:0]               resp_err;

    gf_op_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_width(req_width),
        .req_a(req_a), .req_b(req_b), .req_poly(req_poly), .req_reduc(req_reduc),
        .dp_op_enable(dp_op_enable), .dp_op_finish(dp_op_finish),
        .dp_sum_funct(dp_sum_funct), .dp_exp_funct(dp_exp_funct), .dp_red_funct(dp_red_funct),
        .dp_carry_option(dp_carry_option), .dp_in_width(dp_in_width),
        .dp_in_a(dp_in_a), .dp_in_b(dp_in_b), .dp_polyn(dp_polyn), .dp_reduc(dp_reduc),
        .dp_out(dp_out), .dp_out_poly(dp_out_poly), .dp_out_mult(dp_out_mult), .dp_out_carry(dp_out_carry),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_out(resp_out), .resp_poly(resp_poly), .resp_mult(resp_mult),
        .resp_carry(resp_carry), .resp_err(resp_err)
    );

    function automatic logic [2*DW-1:0] clmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW; i++) if (b[i]) r = r ^ ({{DW{1'b0}}, a} << i);
        return r;
    endfunction

    // Behavioural datapath: finish when enable has been high fin_lat cycles (0 = never);
    // 'stale' also raises finish in the first enabled cycle.
    int   fin_lat = 2;
    logic stale   = 1'b0;
    int   dcnt;
    always @(posedge clk) dcnt <= dp_op_enable ? dcnt + 1 : 0;
    assign dp_op_finish = dp_op_enable && ((fin_lat != 0 && dcnt == fin_lat) || (stale && dcnt == 0));
    assign dp_out       = dp_in_a ^ dp_in_b ^ dp_reduc[DW-1:0] ^ dp_reduc[2*DW-1:DW];
    assign dp_out_poly  = dp_polyn[DW-1:0] ^ {22'b0, dp_in_width, dp_sum_funct, dp_exp_funct,
                                              dp_red_funct, dp_carry_option};
    assign dp_out_mult  = clmul(dp_in_a, dp_in_b);
    assign dp_out_carry = dp_carry_option ^ dp_polyn[DW];

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [IDW-1:0]  id;
        logic [DW-1:0]   out, poly;
        logic [2*DW-1:0] mult;
        logic            carry;
        logic [1:0]      err;
    } resp_t;

    resp_t exp_q[$];
    int    gnt_log[$];
    int    cyc = 0, gnt_cyc = -100, resp_cyc = 0, mg;
    logic  en_after, rv_seen = 1'b0;
    logic  [1:0] last_err;
    logic  [2*DW-1:0] last_mult;
    resp_t e, r;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: push expectation at each grant, compare at each response handshake.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            rv_seen = 1'b0;
        end else begin
            if (cyc == gnt_cyc + 1) en_after = dp_op_enable;
            if (req_ready != '0) begin
                chk("gnt_onehot", 64'($countones(req_ready)), 64'd1);
                mg = 0;
                for (int i = 0; i < NR; i++) if (req_ready[i]) mg = i;
                e.id = IDW'(mg);
                if (req_width[mg] == 0 || req_width[mg] > WW'(DW)) e.err = 2'd1;
                else if (fin_lat == 0) e.err = 2'd2;
                else e.err = 2'd0;
                e.out   = req_a[mg] ^ req_b[mg] ^ req_reduc[mg][DW-1:0] ^ req_reduc[mg][2*DW-1:DW];
                e.poly  = req_poly[mg][DW-1:0] ^ {22'b0, req_width[mg], req_op[mg]};
                e.mult  = clmul(req_a[mg], req_b[mg]);
                e.carry = req_op[mg][0] ^ req_poly[mg][DW];
                if (e.err != 2'd0) begin
                    e.out = '0; e.poly = '0; e.mult = '0; e.carry = 1'b0;
                end
                exp_q.push_back(e);
                gnt_log.push_back(mg);
                gnt_cyc = cyc;
            end
            if (resp_valid && !rv_seen) begin
                rv_seen  = 1'b1;
                resp_cyc = cyc;
                chk("en_low_at_resp", 64'(dp_op_enable), 64'd0);
            end
            if (!resp_valid) rv_seen = 1'b0;
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_id), 64'hDEAD);
                end else begin
                    r = exp_q.pop_front();
                    chk("resp_id",    64'(resp_id),    64'(r.id));
                    chk("resp_err",   64'(resp_err),   64'(r.err));
                    chk("resp_out",   64'(resp_out),   64'(r.out));
                    chk("resp_poly",  64'(resp_poly),  64'(r.poly));
                    chk("resp_mult",  resp_mult,       r.mult);
                    chk("resp_carry", 64'(resp_carry), 64'(r.carry));
                end
                last_err  = resp_err;
                last_mult = resp_mult;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnts(input string nm, input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (gnt_log.size() >= target) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: grants seen %0d, need %0d", nm, gnt_log.size(), target);
        end
    endtask

    task automatic drain(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 700; i++) begin
            tick();
            if (exp_q.size() == 0 && !resp_valid) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: outstanding responses %0d, need 0", nm, exp_q.size());
        end
    endtask

    typedef struct {
        int              id;
        logic [3:0]      op;
        logic [WW-1:0]   w;
        logic [DW-1:0]   a, b;
        logic [2*DW-1:0] reduc;
        int              lat;
        logic            stl;
        logic [1:0]      err;
        logic [2*DW-1:0] mult;
        int              lat_exp;
    } vec_t;

    vec_t vt[8];

    task automatic run_vec(input int k, input vec_t v);
        int n0 = gnt_log.size();
        fin_lat = v.lat;
        stale   = v.stl;
        req_op[v.id]    = v.op;
        req_width[v.id] = v.w;
        req_a[v.id]     = v.a;
        req_b[v.id]     = v.b;
        req_reduc[v.id] = v.reduc;
        req_valid[v.id] = 1'b1;
        wait_gnts($sformatf("v%0d_grant", k), n0 + 1);
        req_valid = '0;
        if (gnt_log.size() > n0) chk($sformatf("v%0d_gnt_id", k), 64'(gnt_log[n0]), 64'(v.id));
        drain($sformatf("v%0d_drain", k));
        stale = 1'b0;
        chk($sformatf("v%0d_err", k), 64'(last_err), 64'(v.err));
        chk($sformatf("v%0d_mult", k), last_mult, v.mult);
        chk($sformatf("v%0d_latency", k), 64'(resp_cyc - gnt_cyc), 64'(v.lat_exp));
        chk($sformatf("v%0d_en_after_grant", k), 64'(en_after), 64'(v.err != 2'd1));
    endtask

    logic [36:0]     snap_hdr;
    logic [2*DW-1:0] snap_mult;
    int              n0;

    initial begin
        vt[0] = '{1, 4'b0000,  8, 32'h3,        32'h5,        64'h0,                   4,   1'b0, 2'd0, 64'hF,                 6};
        vt[1] = '{3, 4'b1001, 32, 32'hFFFFFFFF, 32'h2,        64'h1234_0000_0000_5678, 1,   1'b0, 2'd0, 64'h1_FFFF_FFFE,       3};
        vt[2] = '{0, 4'b0110, 33, 32'h7,        32'h7,        64'h0,                   2,   1'b0, 2'd1, 64'h0,                 1};
        vt[3] = '{2, 4'b0000,  0, 32'h1,        32'h1,        64'h0,                   2,   1'b0, 2'd1, 64'h0,                 1};
        vt[4] = '{0, 4'b0100,  1, 32'h80000000, 32'h80000000, 64'h0,                   2,   1'b0, 2'd0, 64'h4000_0000_0000_0000, 4};
        vt[5] = '{2, 4'b0010, 16, 32'h1234,     32'h0,        64'hFFFF_FFFF_FFFF_FFFF, 3,   1'b1, 2'd0, 64'h0,                 5};
        vt[6] = '{1, 4'b0000,  8, 32'h6,        32'h3,        64'h0,                   0,   1'b0, 2'd2, 64'h0,                 257};
        vt[7] = '{3, 4'b0000,  8, 32'h6,        32'h3,        64'h0,                   255, 1'b0, 2'd0, 64'hA,                 257};

        reset      = 1'b1;
        resp_ready = 1'b1;
        req_valid  = '0;
        for (int i = 0; i < NR; i++) begin
            req_op[i]    = 4'(i);
            req_width[i] = WW'(8 + i);
            req_a[i]     = 32'h100 + 32'(i);
            req_b[i]     = 32'h30 + 32'(i);
            req_poly[i]  = {1'b1, 32'h8D ^ (32'(i) << 8)};
            req_reduc[i] = 64'(i) << 40;
        end

        // Reset state, with requests pending while reset is held
        tick(); tick();
        req_valid = '1;
        tick();
        chk("rst_req_ready",  64'(req_ready),    64'd0);
        chk("rst_dp_enable",  64'(dp_op_enable), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid),   64'd0);
        chk("rst_resp_err",   64'(resp_err),     64'd0);
        chk("rst_dp_in_a",    64'(dp_in_a),      64'd0);
        chk("rst_resp_mult",  resp_mult,         64'd0);
        req_valid = '0;
        reset     = 1'b0;
        tick();

        // All four requesters valid continuously: order 0,1,2,3,0
        fin_lat   = 2;
        n0        = gnt_log.size();
        req_valid = '1;
        wait_gnts("rr_grants", n0 + 5);
        req_valid = '0;
        for (int i = 0; i < 5; i++)
            if (gnt_log.size() > n0 + i) chk($sformatf("rr_order%0d", i), 64'(gnt_log[n0+i]), 64'(i % NR));
        drain("rr_drain");

        for (int k = 0; k < 8; k++) run_vec(k, vt[k]);

        // Response back-pressure: payload held, no grants while waiting
        resp_ready   = 1'b0;
        fin_lat      = 1;
        req_width[2] = 8;
        req_a[2]     = 32'hC0DE;
        req_b[2]     = 32'h11;
        n0           = gnt_log.size();
        req_valid    = 4'b0100;
        wait_gnts("bp_grant", n0 + 1);
        req_valid    = 4'b0011;
        for (int i = 0; i < 20 && !resp_valid; i++) tick();
        chk("bp_resp_valid", 64'(resp_valid), 64'd1);
        snap_hdr  = {resp_id, resp_out, resp_err, resp_carry};
        snap_mult = resp_mult;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", 64'(resp_valid), 64'd1);
            chk("bp_hold_hdr",   64'({resp_id, resp_out, resp_err, resp_carry}), 64'(snap_hdr));
            chk("bp_hold_mult",  resp_mult, snap_mult);
            chk("bp_no_ready",   64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        wait_gnts("bp_next", n0 + 3);
        req_valid = '0;
        if (gnt_log.size() >= n0 + 3) begin
            chk("bp_after0", 64'(gnt_log[n0+1]), 64'd0);
            chk("bp_after1", 64'(gnt_log[n0+2]), 64'd1);
        end
        drain("bp_drain");

        // Reset during RUN: op dropped, pointer back to 0
        fin_lat   = 0;
        n0        = gnt_log.size();
        req_valid = 4'b0010;
        wait_gnts("mr_grant", n0 + 1);
        req_valid = '0;
        tick(); tick();
        chk("mr_running", 64'(dp_op_enable), 64'd1);
        reset = 1'b1;
        tick();
        chk("mr_en_off",    64'(dp_op_enable), 64'd0);
        chk("mr_resp_off",  64'(resp_valid),   64'd0);
        reset     = 1'b0;
        fin_lat   = 2;
        n0        = gnt_log.size();
        req_valid = 4'b1001;
        wait_gnts("mr_regrant", n0 + 1);
        req_valid = '0;
        if (gnt_log.size() > n0) chk("mr_gnt_req0", 64'(gnt_log[n0]), 64'd0);
        drain("mr_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
